reorder_buffer: RTL and testbench
=================================

# reorder_buffer

16-entry in-order reorder buffer downstream of register rename. Each renamed instruction takes one entry at dispatch, in program order. Out-of-order writeback marks entries done. The block retires at most one instruction per cycle from the head and drives the rename commit port (`commit_wb_en`, `commit_P_rd_new`, `commit_P_rd_old`, `commit_A_rd`) plus a one-cycle `recovery` pulse with redirect PC when a mispredicted branch retires.

## Interface
- `DEPTH`, 16, number of entries; must equal the free-list depth in rename.
- `IDX_W`, 4, entry index width, log2(`DEPTH`).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `DC_valid`  in  1  dispatch request this cycle.
- `DC_wb_en`  in  1  instruction writes a destination register.
- `DC_A_rd`  in  6  architectural rd (int + fp space).
- `DC_P_rd_new`  in  7  newly allocated physical rd from rename.
- `DC_P_rd_old`  in  7  previous mapping of `DC_A_rd` from rename.
- `ROB_ready`  out  1  entry available and not recovering; dispatch accepted iff `DC_valid && ROB_ready`.
- `DC_rob_idx`  out  IDX_W  index assigned to the current dispatch (equals tail).
- `WB_valid`  in  1  completion report.
- `WB_rob_idx`  in  IDX_W  completing entry.
- `WB_mispredict`  in  1  completing branch/jump was mispredicted.
- `WB_target`  in  32  correct next PC for a mispredict.
- `commit_valid`  out  1  head entry retires this cycle.
- `commit_wb_en`  out  1  `commit_valid && entry.wb_en`.
- `commit_A_rd`, `commit_P_rd_new`, `commit_P_rd_old`  out  6/7/7  head entry fields; 0 when `commit_valid` is 0.
- `recovery`  out  1  flush pulse to rename and the front end.
- `redirect_pc`  out  32  correct PC; valid while `recovery` is high.

## Operation
- **Entry fields:** valid, done, wb_en, mispredict, A_rd, P_rd_new, P_rd_old, target.
- **Pointers:**
  - `head`, `tail` are IDX_W bits and wrap modulo `DEPTH`.
  - `count` is IDX_W+1 bits, range 0..16.
  - full = (`count` == 16); empty = (`count` == 0).
- **Dispatch:** on accept, write the entry at `tail` with valid=1, done=0, mispredict=0. Then `tail`++ and `count`++.
- **Writeback:**
  - On `WB_valid` with entry valid: set done=1. Load mispredict from `WB_mispredict`, and load target from `WB_target` when mispredicting.
  - Writeback to an invalid entry is ignored.
- **Commit** (combinational from head):
  - `commit_valid` = state NORMAL && head valid && head done.
  - On commit: clear head valid, `head`++, `count`--.
- **Simultaneous dispatch + commit:** `count` is unchanged and both pointers advance.
- **State machine:**
  - NORMAL: when the retiring head has mispredict=1, latch its target into `redirect_pc` and go to RECOVER on the next edge. That commit still drives the commit port normally, so rename's CMT and free-list head update first.
  - RECOVER: lasts exactly one cycle.
    - `recovery`=1; `ROB_ready`=0; `commit_valid`=0; writeback is ignored.
    - On exit, clear all valid bits and set `head`=`tail`=0, `count`=0. Return to NORMAL.
- A dispatch accepted in the same cycle as a mispredict commit is wrong-path; it is flushed by RECOVER.
- `ROB_ready` = NORMAL && !full.
- **Reset** (async, `rst`=0):
  - State: state=NORMAL; `head`=`tail`=0; `count`=0; all valid, done and mispredict bits 0; `redirect_pc`=0.
  - Outputs: `recovery`=0; `ROB_ready`=1 (after release); `DC_rob_idx`=0; all commit outputs 0.
  - Reset mid-operation drops every entry with no commit.

## Timing
- **Dispatch:** accepted at cycle N → entry valid from N+1. `DC_rob_idx` is combinational from `tail` during N.
- **Writeback:** at cycle M → done from M+1. The earliest commit is M+1, provided the entry is at the head. Writeback and commit of the same entry in the same cycle cannot occur.
- **Throughput:** dispatch-to-commit minimum is 2 cycles (dispatch N, writeback N+1, commit N+2). One commit per cycle.
- **Recovery:** mispredict commit at cycle C → `recovery` and `redirect_pc` valid in C+1, `ROB_ready`=0 in C+1. At C+2: `ROB_ready`=1, empty, `DC_rob_idx`=0.
- **Commit outputs** are combinational from the head entry and state register; no input feeds commit outputs combinationally.
- `ROB_ready` depends only on registered state.

## Test plan
- **Reset:** hold `rst`=0 mid-traffic → all commit outputs 0, `recovery`=0. After release, `ROB_ready`=1 and `DC_rob_idx`=0.
- **Fill:** dispatch 16 with no writeback → `ROB_ready`=0 after the 16th. A 17th `DC_valid` is not accepted and `count` stays at 16.
- **In-order retire:**
  - Stimulus: dispatch idx 0..3 (idx 1 with wb_en=0; idx 0 with A_rd=5, P_rd_new=64, P_rd_old=5). Write back in order 3, 1, 2, 0.
  - Response: no commit until idx 0 is done, then commits on 4 consecutive cycles in order 0..3.
  - Idx 0 shows `commit_A_rd`=5, `commit_P_rd_new`=64, `commit_P_rd_old`=5. Idx 1 shows `commit_valid`=1, `commit_wb_en`=0.
- **Mispredict:**
  - Stimulus: entries 0..5; entry 2 written back with mispredict and target 0x0000_1040; entries 0..2 done.
  - Response: commits 0, 1, 2; `recovery`=1 with `redirect_pc`=0x1040 the next cycle. Entries 3..5 are never committed; the ROB is empty afterwards.
- **Wrap-around:** run 40 dispatch/commit pairs at steady state → `DC_rob_idx` wraps 15→0 and commits stay in program order.
- **Simultaneous:** at `count`=15, dispatch and commit in the same cycle → `count` stays 15 and `ROB_ready` stays 1.

Source files
------------

// File: rtl/reorder_buffer.sv
// 16-entry in-order reorder buffer: dispatch at tail, out-of-order writeback,
// single in-order retire from head with a one-cycle flush on mispredict retire.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DC_valid,
  input  logic              DC_wb_en,
  input  logic [5:0]        DC_A_rd,
  input  logic [6:0]        DC_P_rd_new,
  input  logic [6:0]        DC_P_rd_old,
  output logic              ROB_ready,
  output logic [IDX_W-1:0]  DC_rob_idx,
  input  logic              WB_valid,
  input  logic [IDX_W-1:0]  WB_rob_idx,
  input  logic              WB_mispredict,
  input  logic [31:0]       WB_target,
  output logic              commit_valid,
  output logic              commit_wb_en,
  output logic [5:0]        commit_A_rd,
  output logic [6:0]        commit_P_rd_new,
  output logic [6:0]        commit_P_rd_old,
  output logic              recovery,
  output logic [31:0]       redirect_pc
);

  typedef enum logic {S_NORMAL, S_RECOVER} state_t;

  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t            state;
  logic [IDX_W-1:0]  head, tail;
  logic [IDX_W:0]    count;

  logic [DEPTH-1:0]  e_valid, e_done, e_mp, e_wb_en;
  logic [5:0]        e_a_rd    [DEPTH];
  logic [6:0]        e_p_new   [DEPTH];
  logic [6:0]        e_p_old   [DEPTH];
  logic [31:0]       e_target  [DEPTH];

  logic dispatch_fire, wb_hit;

  assign ROB_ready     = (state == S_NORMAL) && (count != CNT_FULL);
  assign DC_rob_idx    = tail;
  assign recovery      = (state == S_RECOVER);
  assign dispatch_fire = DC_valid && ROB_ready;
  assign wb_hit        = WB_valid && (state == S_NORMAL) && e_valid[WB_rob_idx];

  assign commit_valid    = (state == S_NORMAL) && e_valid[head] && e_done[head];
  assign commit_wb_en    = commit_valid && e_wb_en[head];
  assign commit_A_rd     = commit_valid ? e_a_rd[head]  : '0;
  assign commit_P_rd_new = commit_valid ? e_p_new[head] : '0;
  assign commit_P_rd_old = commit_valid ? e_p_old[head] : '0;

  // Payload carries no reset: it is only ever observed behind valid/done.
  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      e_wb_en[tail] <= DC_wb_en;
      e_a_rd[tail]  <= DC_A_rd;
      e_p_new[tail] <= DC_P_rd_new;
      e_p_old[tail] <= DC_P_rd_old;
    end
    if (wb_hit && WB_mispredict) begin
      e_target[WB_rob_idx] <= WB_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_NORMAL;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      e_valid     <= '0;
      e_done      <= '0;
      e_mp        <= '0;
      redirect_pc <= '0;
    end else if (state == S_RECOVER) begin
      state   <= S_NORMAL;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
      e_done  <= '0;
      e_mp    <= '0;
    end else begin
      if (dispatch_fire) begin
        e_valid[tail] <= 1'b1;
        e_done[tail]  <= 1'b0;
        e_mp[tail]    <= 1'b0;
        tail          <= tail + IDX_ONE;
      end
      if (wb_hit) begin
        e_done[WB_rob_idx] <= 1'b1;
        e_mp[WB_rob_idx]   <= WB_mispredict;
      end
      // The mispredicting commit still retires normally; the flush follows a cycle later.
      if (commit_valid) begin
        e_valid[head] <= 1'b0;
        head          <= head + IDX_ONE;
        if (e_mp[head]) begin
          redirect_pc <= e_target[head];
          state       <= S_RECOVER;
        end
      end
      if (dispatch_fire && !commit_valid) begin
        count <= count + CNT_ONE;
      end else if (!dispatch_fire && commit_valid) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized + directed bench for reorder_buffer: a program-order queue model
// predicts handshake signals; a scoreboard monitor checks every retired entry.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        DC_valid = 1'b0, DC_wb_en = 1'b0;
  logic [5:0]  DC_A_rd = '0;
  logic [6:0]  DC_P_rd_new = '0, DC_P_rd_old = '0;
  logic        ROB_ready;
  logic [3:0]  DC_rob_idx;
  logic        WB_valid = 1'b0, WB_mispredict = 1'b0;
  logic [3:0]  WB_rob_idx = '0;
  logic [31:0] WB_target = '0;
  logic        commit_valid, commit_wb_en, recovery;
  logic [5:0]  commit_A_rd;
  logic [6:0]  commit_P_rd_new, commit_P_rd_old;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .DC_valid(DC_valid), .DC_wb_en(DC_wb_en), .DC_A_rd(DC_A_rd),
    .DC_P_rd_new(DC_P_rd_new), .DC_P_rd_old(DC_P_rd_old),
    .ROB_ready(ROB_ready), .DC_rob_idx(DC_rob_idx),
    .WB_valid(WB_valid), .WB_rob_idx(WB_rob_idx),
    .WB_mispredict(WB_mispredict), .WB_target(WB_target),
    .commit_valid(commit_valid), .commit_wb_en(commit_wb_en),
    .commit_A_rd(commit_A_rd), .commit_P_rd_new(commit_P_rd_new),
    .commit_P_rd_old(commit_P_rd_old),
    .recovery(recovery), .redirect_pc(redirect_pc)
  );

  typedef struct {
    bit       wb_en;
    bit [5:0] a;
    bit [6:0] pn;
    bit [6:0] po;
  } exp_t;

  typedef struct {
    bit        wb_en;
    bit [5:0]  a;
    bit [6:0]  pn;
    bit [6:0]  po;
    bit        done;
    bit        mp;
    bit [31:0] tgt;
    int        idx;
  } ment_t;

  exp_t      exp_q[$];
  ment_t     mq[$];
  bit        m_recover = 1'b0;
  int        m_tail = 0;
  bit [31:0] m_redirect = '0;
  int        n_checks = 0;
  int        n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model at posedge.
  task automatic cycle(input bit dv, input bit we, input bit [5:0] a,
                       input bit [6:0] pn, input bit [6:0] po,
                       input bit wv, input bit [3:0] wi, input bit wm,
                       input bit [31:0] wt);
    bit    m_ready, m_commit, acc;
    ment_t c, n;
    exp_t  e;
    m_ready  = !m_recover && (mq.size() < 16);
    m_commit = !m_recover && (mq.size() > 0) && mq[0].done;
    acc      = dv && m_ready;
    DC_valid = dv; DC_wb_en = we; DC_A_rd = a; DC_P_rd_new = pn; DC_P_rd_old = po;
    WB_valid = wv; WB_rob_idx = wi; WB_mispredict = wm; WB_target = wt;
    if (acc) begin
      e.wb_en = we; e.a = a; e.pn = pn; e.po = po;
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("rob_ready", ROB_ready, m_ready);
    chk("dc_rob_idx", DC_rob_idx, m_tail);
    chk("commit_valid", commit_valid, m_commit);
    chk("recovery", recovery, m_recover);
    if (m_recover) chk("redirect_pc", redirect_pc, m_redirect);
    @(posedge clk);
    if (m_recover) begin
      mq.delete();
      m_tail    = 0;
      m_recover = 1'b0;
    end else begin
      if (m_commit) begin
        c = mq.pop_front();
        if (c.mp) begin
          m_recover  = 1'b1;
          m_redirect = c.tgt;
        end
      end
      if (wv) begin
        foreach (mq[k]) begin
          if (mq[k].idx == int'(wi)) begin
            mq[k].done = 1'b1;
            mq[k].mp   = wm;
            if (wm) mq[k].tgt = wt;
          end
        end
      end
      if (acc) begin
        n.wb_en = we; n.a = a; n.pn = pn; n.po = po;
        n.done = 1'b0; n.mp = 1'b0; n.tgt = '0; n.idx = m_tail;
        mq.push_back(n);
        m_tail = (m_tail + 1) % 16;
      end
      if (m_recover) begin
        // Everything younger than the mispredicted branch is wrong-path.
        mq.delete();
        exp_q.delete();
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic disp(input bit we, input bit [5:0] a, input bit [6:0] pn, input bit [6:0] po);
    cycle(1, we, a, pn, po, 0, 0, 0, 0);
  endtask

  task automatic wb(input bit [3:0] idx, input bit mp, input bit [31:0] tgt);
    cycle(0, 0, 0, 0, 0, 1, idx, mp, tgt);
  endtask

  task automatic oldest_pending(output bit found, output bit [3:0] idx);
    found = 1'b0; idx = '0;
    foreach (mq[k]) begin
      if (!found && !mq[k].done) begin
        found = 1'b1;
        idx   = 4'(mq[k].idx);
      end
    end
  endtask

  task automatic rand_cycle(input int p_disp, input int p_wb, input int p_mp);
    int  cand[$];
    bit  used[16];
    bit  wv, wm;
    bit  [3:0] wi;
    int  k;
    foreach (mq[j]) begin
      used[mq[j].idx] = 1'b1;
      if (!mq[j].done) cand.push_back(j);
    end
    wv = 1'b0; wm = 1'b0; wi = '0;
    if (cand.size() > 0 && $urandom_range(99) < p_wb) begin
      k  = cand[$urandom_range(cand.size() - 1)];
      wv = 1'b1;
      wi = 4'(mq[k].idx);
      wm = ($urandom_range(99) < p_mp);
    end else if ($urandom_range(9) == 0) begin
      wi = 4'($urandom_range(15));
      wv = !used[wi];
      wm = 1'($urandom_range(1));
    end
    cycle($urandom_range(99) < p_disp, 1'($urandom_range(1)), 6'($urandom),
          7'($urandom), 7'($urandom), wv, wi, wm, $urandom);
  endtask

  task automatic drain(input int budget);
    bit       f;
    bit [3:0] i;
    for (int c = 0; c < budget && (mq.size() > 0 || m_recover); c++) begin
      oldest_pending(f, i);
      cycle(0, 0, 0, 0, 0, f, i, 0, 0);
    end
    chk("drain_empty", mq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    DC_valid = 1'b0; WB_valid = 1'b0;
    #1;
    chk("reset_commit_valid", commit_valid, 0);
    chk("reset_commit_fields", {commit_wb_en, commit_A_rd, commit_P_rd_new, commit_P_rd_old}, 0);
    chk("reset_recovery", recovery, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete();
    exp_q.delete();
    m_tail    = 0;
    m_recover = 1'b0;
  endtask

  // Scoreboard monitor: every retired entry must match the next one in program order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (commit_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("commit_unexpected", commit_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("commit_wb_en", commit_wb_en, e.wb_en);
          chk("commit_A_rd", commit_A_rd, e.a);
          chk("commit_P_rd_new", commit_P_rd_new, e.pn);
          chk("commit_P_rd_old", commit_P_rd_old, e.po);
        end
      end else begin
        chk("commit_idle_zero", {commit_wb_en, commit_A_rd, commit_P_rd_new, commit_P_rd_old}, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit       f;
    bit [3:0] i;
    do_reset();

    // In-order retire with out-of-order writeback
    disp(1, 6'd5, 7'd64, 7'd5);
    disp(0, 6'd7, 7'd65, 7'd7);
    disp(1, 6'd9, 7'd66, 7'd9);
    disp(1, 6'd33, 7'd67, 7'd33);
    wb(4'd3, 0, 0);
    wb(4'd1, 0, 0);
    wb(4'd2, 0, 0);
    idle(2);
    wb(4'd0, 0, 0);
    idle(5);

    // Reset while the head is ready to retire
    disp(1, 6'd1, 7'd70, 7'd1);
    disp(1, 6'd2, 7'd71, 7'd2);
    wb(4'd4, 0, 0);
    do_reset();
    idle(2);

    // Mispredict: entries 3..5 and a same-cycle dispatch are wrong-path
    for (int k = 0; k < 6; k++) disp(1, 6'(k + 10), 7'(k + 80), 7'(k + 10));
    wb(4'd3, 0, 0);
    wb(4'd0, 0, 0);
    wb(4'd1, 0, 0);
    wb(4'd2, 1, 32'h0000_1040);
    disp(1, 6'd20, 7'd90, 7'd20);
    idle(4);

    // Fill to 16, refused 17th, then dispatch+commit at count 15
    for (int k = 0; k < 16; k++) disp(1'(k), 6'(k), 7'(k + 32), 7'(k));
    disp(1, 6'd63, 7'd127, 7'd63);
    idle(1);
    wb(4'd0, 0, 0);
    idle(1);
    wb(4'd1, 0, 0);
    disp(1, 6'd40, 7'd100, 7'd40);
    idle(1);
    drain(64);

    // Steady-state dispatch/commit pairs across the index wrap
    for (int k = 0; k < 40; k++) begin
      oldest_pending(f, i);
      cycle(1, 1, 6'($urandom), 7'($urandom), 7'($urandom), f, i, 0, 0);
    end
    drain(64);

    // Randomized traffic with occasional mispredicts and mid-traffic reset
    for (int k = 0; k < 600; k++) begin
      rand_cycle(60, 50, 8);
      if (k == 300) do_reset();
    end
    drain(200);
    idle(2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
